// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared constants and helpers for the MIPS five-stage pipeline
package mips_pipe_pkg;

    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
    localparam int          DEF_CTRL_W     = 10;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [5:0]  BEQ_OPCODE     = 6'b000100;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// pipe_reg: pipeline register with hold, synchronous clear and reset value
module pipe_reg #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // reset wins, then hold freezes, then clear beats the load
    always_ff @(posedge clk) begin
        if (rst)
            q <= RST_VAL;
        else if (!hold)
            q <= clr ? '0 : d;
    end

endmodule

// File: rtl/fetch_stall_ctrl.sv
// fetch_stall_ctrl: applies hazard-unit stall/bubble/flush to PC, IF/ID and ID/EX control
module fetch_stall_ctrl
    import mips_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter int          CTRL_W    = DEF_CTRL_W,
    parameter int          MAX_STALL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold_pc,
    input  logic              hold_if_id,
    input  logic              bubble_req,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    output logic [31:0]       imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic [31:0]       if_id_pc4,
    output logic [31:0]       if_id_instr,
    output logic              if_id_valid,
    output logic [CTRL_W-1:0] id_ex_ctrl,
    output logic [31:0]       stall_cycles,
    output logic              stall_timeout
);

    localparam logic [2:0] STALL_LIM = 3'(MAX_STALL);

    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] pc_next;
    logic [2:0]  run_cnt;

    assign imem_addr = pc;
    assign pc4       = pc_plus4(pc);
    assign pc_next   = branch_taken ? branch_target : pc4;

    pipe_reg #(.W(32), .RST_VAL(RESET_PC)) u_pc (
        .clk(clk), .rst(rst), .hold(hold_pc), .clr(1'b0), .d(pc_next), .q(pc)
    );

    pipe_reg #(.W(32), .RST_VAL('0)) u_if_id_pc4 (
        .clk(clk), .rst(rst), .hold(hold_if_id), .clr(branch_taken), .d(pc4), .q(if_id_pc4)
    );

    pipe_reg #(.W(32), .RST_VAL(NOP_INSTR)) u_if_id_instr (
        .clk(clk), .rst(rst), .hold(hold_if_id), .clr(branch_taken), .d(imem_rdata), .q(if_id_instr)
    );

    pipe_reg #(.W(1), .RST_VAL(1'b0)) u_if_id_valid (
        .clk(clk), .rst(rst), .hold(hold_if_id), .clr(branch_taken), .d(1'b1), .q(if_id_valid)
    );

    pipe_reg #(.W(CTRL_W), .RST_VAL('0)) u_id_ex_ctrl (
        .clk(clk), .rst(rst), .hold(1'b0), .clr(bubble_req | !if_id_valid), .d(id_ctrl), .q(id_ex_ctrl)
    );

    // stall statistics: saturating totals, run length and sticky watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles  <= '0;
            run_cnt       <= '0;
            stall_timeout <= 1'b0;
        end else if (hold_pc) begin
            stall_cycles <= stall_cycles + 32'(stall_cycles != '1);
            run_cnt      <= run_cnt + 3'(run_cnt != 3'd7);
            if (run_cnt >= STALL_LIM)
                stall_timeout <= 1'b1;
        end else begin
            run_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// tb_fetch_stall_ctrl: directed vectors with hand-computed expectations
module tb_fetch_stall_ctrl;

    localparam logic [9:0] CTRL = 10'h3C5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold_pc = 1'b0;
    logic        hold_if_id = 1'b0;
    logic        bubble_req = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] imem_addr, imem_rdata, if_id_pc4, if_id_instr, stall_cycles;
    logic        if_id_valid, stall_timeout;
    logic [9:0]  id_ex_ctrl;

    logic [31:0] w_addr, w_rdata, w_pc4, w_instr, w_stall;
    logic        w_valid, w_timeout;
    logic [9:0]  w_ctrl;

    int n_vec = 0;
    int n_err = 0;

    assign imem_rdata = 32'h2000_0000 + imem_addr;
    assign w_rdata    = 32'h2000_0000 + w_addr;

    always #5 clk = ~clk;

    fetch_stall_ctrl #(.RESET_PC(32'h0), .CTRL_W(10), .MAX_STALL(2)) dut (
        .clk(clk), .rst(rst), .hold_pc(hold_pc), .hold_if_id(hold_if_id),
        .bubble_req(bubble_req), .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .id_ctrl(CTRL),
        .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .id_ex_ctrl(id_ex_ctrl), .stall_cycles(stall_cycles), .stall_timeout(stall_timeout)
    );

    fetch_stall_ctrl #(.RESET_PC(32'hFFFF_FFFC), .CTRL_W(10), .MAX_STALL(2)) dut_wrap (
        .clk(clk), .rst(rst), .hold_pc(1'b0), .hold_if_id(1'b0),
        .bubble_req(1'b0), .branch_taken(1'b0), .branch_target(32'h0),
        .imem_addr(w_addr), .imem_rdata(w_rdata), .id_ctrl(CTRL),
        .if_id_pc4(w_pc4), .if_id_instr(w_instr), .if_id_valid(w_valid),
        .id_ex_ctrl(w_ctrl), .stall_cycles(w_stall), .stall_timeout(w_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " pc"}, imem_addr, 32'h0);
        chk({tag, " pc4"}, if_id_pc4, 32'h0);
        chk({tag, " instr"}, if_id_instr, 32'h0);
        chk({tag, " valid"}, 32'(if_id_valid), 32'h0);
        chk({tag, " ctrl"}, 32'(id_ex_ctrl), 32'h0);
        chk({tag, " stalls"}, stall_cycles, 32'h0);
        chk({tag, " timeout"}, 32'(stall_timeout), 32'h0);
        chk({tag, " wrap pc"}, w_addr, 32'hFFFF_FFFC);
    endtask

    initial begin
        step();
        chk_reset("reset");
        rst = 1'b0;
        step();
        chk("wrap pc", w_addr, 32'h0);
        chk("run1 ctrl", 32'(id_ex_ctrl), 32'h0);
        step();
        chk("run2 ctrl", 32'(id_ex_ctrl), 32'(CTRL));
        step();
        chk("run3 pc", imem_addr, 32'd12);
        chk("run3 instr", if_id_instr, 32'h2000_0008);
        chk("run3 pc4", if_id_pc4, 32'd12);
        chk("run3 valid", 32'(if_id_valid), 32'h1);
        step();
        chk("pre stall pc", imem_addr, 32'd16);
        hold_pc = 1'b1; hold_if_id = 1'b1; bubble_req = 1'b1;
        step();
        hold_pc = 1'b0; hold_if_id = 1'b0; bubble_req = 1'b0;
        chk("stall pc", imem_addr, 32'd16);
        chk("stall instr", if_id_instr, 32'h2000_000C);
        chk("stall pc4", if_id_pc4, 32'd16);
        chk("stall bubble", 32'(id_ex_ctrl), 32'h0);
        chk("stall count", stall_cycles, 32'd1);
        chk("stall timeout", 32'(stall_timeout), 32'h0);
        step();
        chk("post stall pc", imem_addr, 32'd20);
        chk("post stall instr", if_id_instr, 32'h2000_0010);
        chk("post stall ctrl", 32'(id_ex_ctrl), 32'(CTRL));
        branch_taken = 1'b1; branch_target = 32'h100;
        step();
        branch_taken = 1'b0;
        chk("br pc", imem_addr, 32'h100);
        chk("br valid", 32'(if_id_valid), 32'h0);
        chk("br instr", if_id_instr, 32'h0);
        chk("br ctrl", 32'(id_ex_ctrl), 32'(CTRL));
        step();
        chk("br+1 pc", imem_addr, 32'h104);
        chk("br+1 pc4", if_id_pc4, 32'h104);
        chk("br+1 instr", if_id_instr, 32'h2000_0100);
        chk("br+1 valid", 32'(if_id_valid), 32'h1);
        chk("br+1 ctrl", 32'(id_ex_ctrl), 32'h0);
        hold_pc = 1'b1; hold_if_id = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
        step();
        hold_pc = 1'b0; hold_if_id = 1'b0;
        chk("hold+br pc", imem_addr, 32'h104);
        chk("hold+br valid", 32'(if_id_valid), 32'h1);
        chk("hold+br instr", if_id_instr, 32'h2000_0100);
        chk("hold+br count", stall_cycles, 32'd2);
        step();
        branch_taken = 1'b0;
        chk("release br pc", imem_addr, 32'h200);
        chk("release br valid", 32'(if_id_valid), 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset("reset2");
        hold_pc = 1'b1; hold_if_id = 1'b1;
        step();
        step();
        chk("wd2 timeout", 32'(stall_timeout), 32'h0);
        chk("wd2 pc", imem_addr, 32'h0);
        step();
        chk("wd3 timeout", 32'(stall_timeout), 32'h1);
        chk("wd3 count", stall_cycles, 32'd3);
        hold_pc = 1'b0; hold_if_id = 1'b0;
        step();
        chk("wd sticky", 32'(stall_timeout), 32'h1);
        chk("wd released pc", imem_addr, 32'd4);
        hold_pc = 1'b1; hold_if_id = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; hold_pc = 1'b0; hold_if_id = 1'b0;
        chk_reset("mid-stall reset");
        step();
        chk("wrap after reset", w_addr, 32'h0);
        chk("main after reset", imem_addr, 32'd4);
        hold_if_id = 1'b1;
        step();
        hold_if_id = 1'b0;
        chk("split hold pc", imem_addr, 32'd8);
        chk("split hold instr", if_id_instr, 32'h2000_0000);
        chk("split hold pc4", if_id_pc4, 32'd4);
        chk("split hold count", stall_cycles, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stall_ctrl.md
# fetch_stall_ctrl

Applies the stall and bubble decisions from the hazard detection unit to the pipeline state of the MIPS five-stage pipeline. It owns three things:
- the program counter;
- the IF/ID pipeline register;
- the control half of the ID/EX register.

It executes PC hold, IF/ID hold, bubble insertion and branch-taken flush. It also keeps stall statistics and a stall-watchdog flag for verification and debug.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CTRL_W, 10, width of the decoded control bundle passed ID→EX
- MAX_STALL, 2, longest legal run of consecutive stall cycles

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- hold_pc  in  1  freeze PC this cycle
- hold_if_id  in  1  freeze IF/ID register this cycle
- bubble_req  in  1  force ID/EX control to zero (insert NOP)
- branch_taken  in  1  beq resolved taken in ID
- branch_target  in  32  target address for taken branch
- imem_addr  out  32  instruction memory address (= current PC)
- imem_rdata  in  32  instruction word, combinational read of imem_addr
- id_ctrl  in  CTRL_W  control bundle from main decoder for IF/ID instruction
- if_id_pc4  out  32  registered PC+4 of instruction in ID
- if_id_instr  out  32  registered instruction in ID
- if_id_valid  out  1  ID holds a real instruction
- id_ex_ctrl  out  CTRL_W  registered control bundle in EX
- stall_cycles  out  32  total cycles with hold_pc=1, saturating
- stall_timeout  out  1  sticky: stall run exceeded MAX_STALL

## Operation
- Reset (rst=1 at edge):
  - PC←RESET_PC.
  - if_id_pc4←0, if_id_instr←0 (NOP), if_id_valid←0.
  - id_ex_ctrl←0.
  - stall_cycles←0, run counter←0, stall_timeout←0.
  - Reset overrides every other input.
- PC update priority:
  1. hold_pc: PC unchanged. A branch in ID is not yet resolved while stalled, so branch_taken is ignored.
  2. branch_taken: PC←branch_target.
  3. Otherwise: PC←PC+4, modulo 2^32; wrap 32'hFFFF_FFFC→0 is legal.
- IF/ID update priority:
  1. hold_if_id: all three fields unchanged.
  2. branch_taken: flush. instr←0, pc4←0, valid←0.
  3. Otherwise: pc4←PC+4, instr←imem_rdata, valid←1.
- ID/EX control:
  - If bubble_req=1 or if_id_valid=0: id_ex_ctrl←0.
  - Otherwise: id_ex_ctrl←id_ctrl.
  - A branch flush clears IF/ID only; the branch itself proceeds to EX.
- hold_pc and hold_if_id are normally equal. If they differ, each register obeys its own hold; no correction is applied.
- Stall statistics:
  - stall_cycles increments by 1 in every cycle with hold_pc=1 and saturates at 32'hFFFF_FFFF.
  - The run counter (3 bits, saturating at 7) increments while hold_pc=1 and clears to 0 on any cycle with hold_pc=0.
  - stall_timeout sets when the run counter would reach MAX_STALL+1, and stays set until rst.

## Timing
- imem_addr is combinational from the PC register. It is valid for the whole cycle following each update.
- Fetch latency: PC→IF/ID is one edge. The instruction fetched at PC=A appears on if_id_instr one cycle after A is on imem_addr.
- A bubble is visible on id_ex_ctrl one edge after bubble_req is sampled high.
- Branch taken sampled at edge N: at N, PC=branch_target and IF/ID is flushed. The target instruction reaches IF/ID at edge N+1. Branch penalty is one cycle.
- Simultaneous hold_pc=1 and branch_taken=1: PC holds, IF/ID holds if hold_if_id=1, no flush.
- rst mid-stall: all state returns to reset values at that edge. Statistics clear.

## Structure
- Shared package mips_pipe_pkg holds:
  - NOP_INSTR = 32'h0000_0000
  - CTRL_W default
  - RESET_PC default
  - BEQ_OPCODE = 6'b000100
- One sub-module, pipe_reg: a parameterised width with enable (hold), synchronous clear and reset value. It is instantiated for the PC, the IF/ID fields and the ID/EX control.
- Counters and the watchdog live in the top level.

## Test plan
- Reset then free-run, imem returns 32'h2000_0000+addr: after reset imem_addr=0; after 3 edges PC=12, if_id_instr=32'h2000_0008, if_id_pc4=12, if_id_valid=1.
- Load-use stall, one-cycle pulse of hold_pc=hold_if_id=bubble_req=1 at PC=16:
  - PC stays 16 for one extra cycle.
  - IF/ID is unchanged.
  - id_ex_ctrl=0 for exactly one cycle.
  - stall_cycles=1, stall_timeout=0.
- Branch taken, branch_taken=1 with target 32'h0000_0100 at PC=20:
  - next PC=0x100, if_id_valid=0, if_id_instr=0.
  - following edge: if_id_pc4=0x104, if_id_valid=1.
- Simultaneous hold_pc=1 and branch_taken=1: PC unchanged and no flush; after release with branch_taken=1, redirect happens.
- Watchdog: hold_pc high for 3 consecutive cycles with MAX_STALL=2: stall_timeout rises after the third stall edge and stays 1 after hold drops; stall_cycles=3.
- Reset mid-stall, then PC wrap:
  - rst asserted during a stall: all outputs return to reset values at that edge.
  - RESET_PC=32'hFFFF_FFFC: one edge after reset release, PC=0.
